alu_selftest: RTL and testbench

ALU_SELFTEST -- requirements
Module: alu_selftest

---
 rtl/alu_selftest.sv | 197 +++++++++++++++++++
 tb/tb_alu_selftest.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_selftest.sv
// Built-in self-test sequencer for a 4-bit ALU: walks a fixed 8-entry vector table and scores res_i.
// Optional build macro ALU_SELFTEST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module alu_selftest #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] res_i,
   output logic [3:0] a_o,
   output logic [3:0] b_o,
   output logic [1:0] sel_o,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_cnt,
   output logic [2:0] fail_idx
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] sel;
   } vec_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   function automatic vec_t vec_lookup(input logic [2:0] idx);
      vec_t v;
      case (idx)
         3'd0:    v = {4'd3,  4'd1, 2'b00};
         3'd1:    v = {4'd15, 4'd2, 2'b00};
         3'd2:    v = {4'd7,  4'd3, 2'b01};
         3'd3:    v = {4'd7,  4'd8, 2'b01};
         3'd4:    v = {4'd8,  4'd2, 2'b10};
         3'd5:    v = {4'd7,  4'd1, 2'b10};
         3'd6:    v = {4'd14, 4'd3, 2'b11};
         3'd7:    v = {4'd10, 4'd2, 2'b11};
         default: v = {4'd0,  4'd0, 2'b00};
      endcase
      return v;
   endfunction

   function automatic logic [3:0] alu_golden(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] sel);
      logic [3:0] r;
      case (sel)
         2'b00:   r = a + b;
         2'b01:   r = a - b;
         2'b10:   r = a & b;
         2'b11:   r = a | b;
         default: r = 4'd0;
      endcase
      return r;
   endfunction

   state_t     state_r, state_s;
   logic [2:0] idx_r, idx_s;
   logic [3:0] settle_r, settle_s;
   logic [3:0] a_s, b_s;
   logic [1:0] sel_s;
   logic       busy_s, done_s, pass_s;
   logic [3:0] fail_cnt_s;
   logic [2:0] fail_idx_s;
   vec_t       cur_v, first_v, next_v;
   logic       mismatch_s;

   // Next-state and next-output logic; every register holds by default.
   always_comb begin
      state_s    = state_r;
      idx_s      = idx_r;
      settle_s   = settle_r;
      a_s        = a_o;
      b_s        = b_o;
      sel_s      = sel_o;
      busy_s     = busy;
      done_s     = done;
      fail_cnt_s = fail_cnt;
      fail_idx_s = fail_idx;
      cur_v      = vec_lookup(idx_r);
      first_v    = vec_lookup(3'd0);
      next_v     = vec_lookup(idx_r + 3'd1);
      mismatch_s = (res_i != alu_golden(cur_v.a, cur_v.b, cur_v.sel));

      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_s    = DRIVE;
               idx_s      = 3'd0;
               settle_s   = 4'd0;
               a_s        = first_v.a;
               b_s        = first_v.b;
               sel_s      = first_v.sel;
               busy_s     = 1'b1;
               done_s     = 1'b0;
               fail_cnt_s = 4'd0;
               fail_idx_s = 3'd0;
            end else begin
               state_s = state_r;
            end
         end
         DRIVE: begin
            if (settle_r == SETTLE_LAST) begin
               state_s  = SAMPLE;
               settle_s = 4'd0;
            end else begin
               settle_s = settle_r + 4'd1;
            end
         end
         SAMPLE: begin
            settle_s = 4'd0;
            if (mismatch_s) begin
               if (fail_cnt != 4'd15) begin
                  fail_cnt_s = fail_cnt + 4'd1;
               end else begin
                  fail_cnt_s = fail_cnt;
               end
               // Only the first failure records its index.
               if (fail_cnt == 4'd0) begin
                  fail_idx_s = idx_r;
               end else begin
                  fail_idx_s = fail_idx;
               end
            end else begin
               fail_cnt_s = fail_cnt;
            end
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
            if (mismatch_s || (idx_r == 3'd7)) begin
               state_s = DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
            end else begin
               state_s = DRIVE;
               idx_s   = idx_r + 3'd1;
               a_s     = next_v.a;
               b_s     = next_v.b;
               sel_s   = next_v.sel;
            end
`else
            if (idx_r == 3'd7) begin
               state_s = DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
            end else begin
               state_s = DRIVE;
               idx_s   = idx_r + 3'd1;
               a_s     = next_v.a;
               b_s     = next_v.b;
               sel_s   = next_v.sel;
            end
`endif
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      pass_s = done_s & (fail_cnt_s == 4'd0);
   end

   // State, sequencing and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         idx_r    <= 3'd0;
         settle_r <= 4'd0;
         a_o      <= 4'd0;
         b_o      <= 4'd0;
         sel_o    <= 2'b00;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         fail_cnt <= 4'd0;
         fail_idx <= 3'd0;
      end else begin
         state_r  <= state_s;
         idx_r    <= idx_s;
         settle_r <= settle_s;
         a_o      <= a_s;
         b_o      <= b_s;
         sel_o    <= sel_s;
         busy     <= busy_s;
         done     <= done_s;
         pass     <= pass_s;
         fail_cnt <= fail_cnt_s;
         fail_idx <= fail_idx_s;
      end
   end

endmodule

// File: tb/tb_alu_selftest.sv
// Self-checking bench for alu_selftest: behavioural ALU (correct or faulty) on res_i, reference
// scoring computed from the vector table, two instances (SETTLE_CYCLES 1 and 3).
module tb_alu_selftest;

   localparam int S1 = 1;
   localparam int S3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start1 = 1'b0, start3 = 1'b0;
   logic [3:0] res1, res3, a1, b1, a3, b3, fc1, fc3;
   logic [1:0] sel1, sel3;
   logic       busy1, done1, pass1, busy3, done3, pass3;
   logic [2:0] fi1, fi3;

   int         mode = 0;
   logic [7:0] bad = 8'd0;
   logic [3:0] flip = 4'd1;
   int         inst = 1;
   int         passed = 0;
   int         total = 0;

   logic [3:0] ta [8] = '{4'd3, 4'd15, 4'd7, 4'd7, 4'd8, 4'd2 + 4'd5, 4'd14, 4'd10};
   logic [3:0] tb [8] = '{4'd1, 4'd2, 4'd3, 4'd8, 4'd2, 4'd1, 4'd3, 4'd2};
   logic [1:0] ts [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
   logic [3:0] te [8] = '{4'd4, 4'd1, 4'd4, 4'd15, 4'd0, 4'd1, 4'd15, 4'd10};

   // Modes: 0 correct ALU, 1 subtract reversed (B-A), 2 output stuck at F, 3 flip bits on chosen vectors.
   function automatic logic [3:0] alu_model(input int m, input logic [3:0] a, input logic [3:0] b,
                                            input logic [1:0] s, input logic [7:0] bm,
                                            input logic [3:0] fl);
      logic [3:0] r;
      case (s)
         2'd0:    r = a + b;
         2'd1:    r = (m == 1) ? b - a : a - b;
         2'd2:    r = a & b;
         default: r = a | b;
      endcase
      if (m == 2) r = 4'hF;
      if (m == 3)
         for (int k = 0; k < 8; k++)
            if (a == ta[k] && b == tb[k] && s == ts[k] && bm[k]) r = r ^ fl;
      return r;
   endfunction

   always_comb res1 = alu_model(mode, a1, b1, sel1, bad, flip);
   always_comb res3 = alu_model(mode, a3, b3, sel3, bad, flip);

   alu_selftest #(.SETTLE_CYCLES(S1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .res_i(res1), .a_o(a1), .b_o(b1), .sel_o(sel1),
      .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1), .fail_idx(fi1));

   alu_selftest #(.SETTLE_CYCLES(S3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .res_i(res3), .a_o(a3), .b_o(b3), .sel_o(sel3),
      .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fc3), .fail_idx(fi3));

   logic [3:0] oa, ob, ofc;
   logic [1:0] osel;
   logic       obusy, odone, opass;
   logic [2:0] ofi;
   always_comb begin
      if (inst == 3) begin
         oa = a3; ob = b3; osel = sel3; obusy = busy3; odone = done3; opass = pass3;
         ofc = fc3; ofi = fi3;
      end else begin
         oa = a1; ob = b1; osel = sel1; obusy = busy1; odone = done1; opass = pass1;
         ofc = fc1; ofi = fi1;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_start(input logic v);
      if (inst == 3) start3 = v;
      else start1 = v;
   endtask

   // One full run on the selected instance, scored against the table-derived reference.
   task automatic run(input string tag, input bit repulse);
      int s, lat, stop_k, exp_cnt, exp_idx, exp_lat, k, bad_trace;
      bit found;
      s = (inst == 3) ? S3 : S1;
      exp_cnt = 0; exp_idx = 0; found = 1'b0; stop_k = 7;
      for (int v = 0; v < 8; v++)
         if (alu_model(mode, ta[v], tb[v], ts[v], bad, flip) != te[v]) begin
            if (!found) begin found = 1'b1; exp_idx = v; end
            exp_cnt++;
         end
      exp_lat = 8 * (s + 1);
`ifdef ALU_SELFTEST_STOP_ON_FAIL_EN
      if (found) begin exp_cnt = 1; stop_k = exp_idx; exp_lat = (exp_idx + 1) * (s + 1); end
`endif
      set_start(1'b1);
      tick;
      set_start(1'b0);
      check({tag, "_busy_start"}, obusy, 1);
      check({tag, "_done_clr"}, {odone, opass, ofc, ofi}, 0);
      bad_trace = -1;
      if ({oa, ob, osel} !== {ta[0], tb[0], ts[0]}) bad_trace = 0;
      lat = 0;
      while (!odone && lat < 300) begin
         set_start(repulse && lat == 3);
         tick;
         set_start(1'b0);
         lat++;
         k = lat / (s + 1);
         if (k > stop_k) k = stop_k;
         if (bad_trace < 0 && (({oa, ob, osel} !== {ta[k], tb[k], ts[k]}) || (!odone && !obusy)))
            bad_trace = lat;
      end
      check({tag, "_trace"}, bad_trace, -1);
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_busy_end"}, {obusy, odone}, 2'b01);
      check({tag, "_fail_cnt"}, ofc, exp_cnt);
      check({tag, "_fail_idx"}, ofi, exp_idx);
      check({tag, "_pass"}, opass, (exp_cnt == 0));
      repeat (3) tick;
      check({tag, "_hold"}, {odone, ofc, ofi, oa, ob, osel},
            {1'b1, 4'(exp_cnt), 3'(exp_idx), ta[stop_k], tb[stop_k], ts[stop_k]});
   endtask

   initial begin
      tick;
      tick;
      check("reset_outputs", {a1, b1, sel1, busy1, done1, pass1, fc1, fi1}, 0);
      rst = 1'b0;
      repeat (3) tick;
      check("idle_after_reset", {busy1, done1, busy3, done3}, 0);

      mode = 0; run("good", 1'b0);
      mode = 1; run("b_minus_a", 1'b0);
      mode = 0; run("after_fail_repulse", 1'b1);
      mode = 2; run("tied_f", 1'b0);

      // Reset in the middle of vector 4's drive phase.
      mode = 0;
      start1 = 1'b1; tick; start1 = 1'b0;
      repeat (8) tick;
      check("pre_rst_vec4", {a1, b1, sel1, busy1}, {ta[4], tb[4], ts[4], 1'b1});
      rst = 1'b1;
      #1;
      check("rst_async", {a1, b1, sel1, busy1, done1, pass1, fc1, fi1}, 0);
      tick;
      rst = 1'b0;
      repeat (3) tick;
      check("rst_stays_idle", {a1, b1, sel1, busy1, done1, pass1, fc1, fi1}, 0);
      run("after_rst", 1'b0);

      mode = 3;
      for (int i = 0; i < 6; i++) begin
         bad = 8'($urandom_range(0, 255));
         flip = 4'($urandom_range(1, 15));
         run($sformatf("rand%0d", i), 1'b0);
      end

      inst = 3;
      mode = 0; bad = 8'd0; run("settle3_good", 1'b0);
      mode = 1; run("settle3_b_minus_a", 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
